// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Register controls are {EN,CLR}: EN loads a bubble, CLR holds.
package hazard_ctrl_pkg;

  localparam int RW_DEF       = 5;
  localparam int MDIV_LAT_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdiv_state_e;

  typedef struct packed {
    logic en;
    logic clr;
  } regctl_t;

  localparam regctl_t PASS   = '{en: 1'b0, clr: 1'b0};
  localparam regctl_t HOLD   = '{en: 1'b0, clr: 1'b1};
  localparam regctl_t BUBBLE = '{en: 1'b1, clr: 1'b0};

endpackage

// File: rtl/hazard_ctrl_mdiv_tracker.sv
// Multiply/divide occupancy tracker: IDLE/BUSY FSM with a
// down-counter covering MDIV_LAT busy cycles per operation.
module mdiv_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MDIV_LAT = MDIV_LAT_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CNTW = $clog2(MDIV_LAT);

  mdiv_state_e     state;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CNTW'(MDIV_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset is synchronous, so mask the still-BUSY state while RST_N is low
  assign busy = RST_N & (state == BUSY);
  assign done = busy & (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch flush and
// mul/div occupancy drive the pipeline register controls and PC hold.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RW       = RW_DEF,
  parameter int MDIV_LAT = MDIV_LAT_DEF,
  parameter int CW       = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_mdiv_start,
  input  logic          id_mdiv_read,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_dest,
  input  logic          ex_branch_taken,
  output logic          pc_hold,
  output logic          ifid_EN,
  output logic          ifid_CLR,
  output logic          idex_EN,
  output logic          idex_CLR,
  output logic          exmem_EN,
  output logic          exmem_CLR,
  output logic          mdiv_busy,
  output logic          mdiv_done,
  output logic [CW-1:0] stall_cnt
);

  logic    load_use;
  logic    mdiv_hz;
  logic    accept;
  regctl_t ifid;
  regctl_t idex;
  regctl_t exmem;

  assign load_use = ex_memread & (ex_dest != '0) &
                    ((id_uses_rs & (id_rs == ex_dest)) |
                     (id_uses_rt & (id_rt == ex_dest)));

  assign mdiv_hz = mdiv_busy & (id_mdiv_read | id_mdiv_start);

  // A wrong-path or stalled MULT/DIV must not start the unit
  assign accept = id_mdiv_start & ~ex_branch_taken & ~load_use;

  mdiv_tracker #(
    .MDIV_LAT(MDIV_LAT)
  ) u_mdiv (
    .CLK  (CLK),
    .RST_N(RST_N),
    .start(accept),
    .busy (mdiv_busy),
    .done (mdiv_done)
  );

  always_comb begin
    ifid    = PASS;
    idex    = PASS;
    exmem   = PASS;
    pc_hold = 1'b0;
    priority case (1'b1)
      !RST_N: begin
        ifid    = BUBBLE;
        idex    = BUBBLE;
        exmem   = BUBBLE;
        pc_hold = 1'b1;
      end
      ex_branch_taken: begin
        ifid = BUBBLE;
        idex = BUBBLE;
      end
      load_use | mdiv_hz: begin
        ifid    = HOLD;
        idex    = BUBBLE;
        pc_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign ifid_EN   = ifid.en;
  assign ifid_CLR  = ifid.clr;
  assign idex_EN   = idex.en;
  assign idex_CLR  = idex.clr;
  assign exmem_EN  = exmem.en;
  assign exmem_CLR = exmem.clr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (pc_hold && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second CW=4 instance on the
// same inputs exercises stall counter saturation.
module tb_hazard_ctrl;

  logic       CLK;
  logic       RST_N;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_uses_rs, id_uses_rt;
  logic       id_mdiv_start, id_mdiv_read;
  logic       ex_memread, ex_branch_taken;

  logic        pc_hold, ifid_EN, ifid_CLR, idex_EN, idex_CLR;
  logic        exmem_EN, exmem_CLR, mdiv_busy, mdiv_done;
  logic [15:0] stall_cnt;

  logic        s_pc_hold, s_ifid_EN, s_ifid_CLR, s_idex_EN, s_idex_CLR;
  logic        s_exmem_EN, s_exmem_CLR, s_mdiv_busy, s_mdiv_done;
  logic [3:0]  s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.RW(5), .MDIV_LAT(8), .CW(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdiv_start(id_mdiv_start), .id_mdiv_read(id_mdiv_read),
    .ex_memread(ex_memread), .ex_dest(ex_dest),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold),
    .ifid_EN(ifid_EN), .ifid_CLR(ifid_CLR),
    .idex_EN(idex_EN), .idex_CLR(idex_CLR),
    .exmem_EN(exmem_EN), .exmem_CLR(exmem_CLR),
    .mdiv_busy(mdiv_busy), .mdiv_done(mdiv_done),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.RW(5), .MDIV_LAT(8), .CW(4)) dut_sat (
    .CLK(CLK), .RST_N(RST_N),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdiv_start(id_mdiv_start), .id_mdiv_read(id_mdiv_read),
    .ex_memread(ex_memread), .ex_dest(ex_dest),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(s_pc_hold),
    .ifid_EN(s_ifid_EN), .ifid_CLR(s_ifid_CLR),
    .idex_EN(s_idex_EN), .idex_CLR(s_idex_CLR),
    .exmem_EN(s_exmem_EN), .exmem_CLR(s_exmem_CLR),
    .mdiv_busy(s_mdiv_busy), .mdiv_done(s_mdiv_done),
    .stall_cnt(s_stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks sample 1ns later
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic clr_inputs();
    id_rs = '0; id_rt = '0; ex_dest = '0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_mdiv_start = 0; id_mdiv_read = 0;
    ex_memread = 0; ex_branch_taken = 0;
  endtask

  initial begin
    RST_N = 1'b0;
    clr_inputs();
    step();
    step();
    #1;
    chk("rst_ifid_en", 32'(ifid_EN), 1);
    chk("rst_idex_en", 32'(idex_EN), 1);
    chk("rst_exmem_en", 32'(exmem_EN), 1);
    chk("rst_ifid_clr", 32'(ifid_CLR), 0);
    chk("rst_pc_hold", 32'(pc_hold), 1);
    chk("rst_busy", 32'(mdiv_busy), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_scnt", 32'(s_stall_cnt), 0);

    step(); RST_N = 1'b1; #1;
    chk("idle_pc_hold", 32'(pc_hold), 0);
    chk("idle_ifid_en", 32'(ifid_EN), 0);
    chk("idle_idex_en", 32'(idex_EN), 0);

    // load-use via rs
    step();
    ex_memread = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    #1;
    chk("lu_pc_hold", 32'(pc_hold), 1);
    chk("lu_ifid_clr", 32'(ifid_CLR), 1);
    chk("lu_ifid_en", 32'(ifid_EN), 0);
    chk("lu_idex_en", 32'(idex_EN), 1);
    chk("lu_idex_clr", 32'(idex_CLR), 0);
    chk("lu_exmem_en", 32'(exmem_EN), 0);
    chk("lu_exmem_clr", 32'(exmem_CLR), 0);
    chk("lu_cnt_before", 32'(stall_cnt), 0);

    // ex_dest = 0 never stalls
    step(); ex_dest = 0; id_rs = 0; #1;
    chk("dest0_pc_hold", 32'(pc_hold), 0);
    chk("lu_cnt_after", 32'(stall_cnt), 1);

    // load-use via rt
    step(); ex_dest = 7; id_rt = 7; id_uses_rt = 1; id_uses_rs = 0; #1;
    chk("lu_rt_pc_hold", 32'(pc_hold), 1);
    step(); id_uses_rt = 0; #1;
    chk("rt_unused_pc_hold", 32'(pc_hold), 0);
    chk("lu_rt_cnt", 32'(stall_cnt), 2);

    // branch over hazard, with a wrong-path MULT in ID
    step(); id_uses_rt = 1; ex_branch_taken = 1; id_mdiv_start = 1; #1;
    chk("br_ifid_en", 32'(ifid_EN), 1);
    chk("br_idex_en", 32'(idex_EN), 1);
    chk("br_pc_hold", 32'(pc_hold), 0);
    chk("br_ifid_clr", 32'(ifid_CLR), 0);
    step(); clr_inputs(); #1;
    chk("br_cnt", 32'(stall_cnt), 2);
    chk("br_no_start", 32'(mdiv_busy), 0);

    // MULT occupancy
    step(); id_mdiv_start = 1; #1;
    chk("mul_accept_busy", 32'(mdiv_busy), 0);
    chk("mul_accept_hold", 32'(pc_hold), 0);
    step(); id_mdiv_start = 0; id_mdiv_read = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("mul_busy_%0d", i), 32'(mdiv_busy), 1);
      chk($sformatf("mul_hold_%0d", i), 32'(pc_hold), 1);
      chk($sformatf("mul_done_%0d", i), 32'(mdiv_done), (i == 7) ? 1 : 0);
      step();
    end
    #1;
    chk("mul_end_busy", 32'(mdiv_busy), 0);
    chk("mul_end_hold", 32'(pc_hold), 0);
    chk("mul_end_done", 32'(mdiv_done), 0);
    chk("mul_cnt", 32'(stall_cnt), 10);
    id_mdiv_read = 0;

    // back-to-back MULT
    step(); id_mdiv_start = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_busy1_%0d", i), 32'(mdiv_busy), 1);
      chk($sformatf("b2b_hold1_%0d", i), 32'(pc_hold), 1);
      chk($sformatf("b2b_done1_%0d", i), 32'(mdiv_done), (i == 7) ? 1 : 0);
      step();
    end
    #1;
    chk("b2b_gap_busy", 32'(mdiv_busy), 0);
    chk("b2b_gap_hold", 32'(pc_hold), 0);
    step(); id_mdiv_start = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_busy2_%0d", i), 32'(mdiv_busy), 1);
      chk($sformatf("b2b_done2_%0d", i), 32'(mdiv_done), (i == 7) ? 1 : 0);
      step();
    end
    #1;
    chk("b2b_end_busy", 32'(mdiv_busy), 0);
    chk("b2b_cnt", 32'(stall_cnt), 18);

    // reset on busy cycle 3
    step(); id_mdiv_start = 1;
    step(); id_mdiv_start = 0; #1;
    chk("rb_busy1", 32'(mdiv_busy), 1);
    step();
    step(); RST_N = 1'b0; #1;
    chk("rb_low_busy", 32'(mdiv_busy), 0);
    chk("rb_low_done", 32'(mdiv_done), 0);
    chk("rb_low_ifid_en", 32'(ifid_EN), 1);
    chk("rb_low_idex_en", 32'(idex_EN), 1);
    chk("rb_low_exmem_en", 32'(exmem_EN), 1);
    chk("rb_low_hold", 32'(pc_hold), 1);
    step(); RST_N = 1'b1; #1;
    chk("rb_busy", 32'(mdiv_busy), 0);
    chk("rb_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      chk($sformatf("rb_no_done_%0d", i), 32'(mdiv_done), 0);
    end

    // saturation of the CW=4 counter under a 20-cycle load-use
    step(); ex_memread = 1; ex_dest = 3; id_rt = 3; id_uses_rt = 1;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("sat_scnt", 32'(s_stall_cnt), 15);
    chk("sat_cnt", 32'(stall_cnt), 20);
    step(); #1;
    chk("sat_scnt_hold", 32'(s_stall_cnt), 15);
    clr_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
